// File: rtl/tron_pkg.sv
// Shared types and frame-geometry constants for the trail painter.
package tron_pkg;
  localparam int H_WORDS = 320;
  localparam int V_LINES = 480;
  localparam int CELL_PX = 4;
  localparam int GRID_W  = 160;
  localparam int GRID_H  = 120;

  typedef enum logic [1:0] {CLEAR, IDLE, PAINT_B, PAINT_R} painter_state_t;

  typedef enum logic [3:0] {
    RED_TRAIL  = 4'h4,
    BLUE_TRAIL = 4'h6,
    BLOCKED    = 4'h7,
    BG_COLOR   = 4'h8,
    COLLIDE    = 4'hE
  } colour_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } cell_t;

  // Both pixels of a buffer word take the same colour.
  function automatic logic [15:0] pix_word(colour_t c);
    return {4'h0, c, 4'h0, c};
  endfunction
endpackage

// File: rtl/trail_painter_if.sv
// Frame-buffer write port: one word per cycle while WE is high.
interface trail_painter_if;
  logic        WE;
  logic [18:0] write_address;
  logic [15:0] Data_In;

  modport master (output WE, write_address, Data_In);
  modport slave  (input  WE, write_address, Data_In);
endinterface

// File: rtl/trail_painter_frame_tick_sync.sv
// Brings the asynchronous frame strobe into Clk and emits a one-cycle tick per rising edge.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);
  logic [2:0] sync_pipe;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_pipe <= '0;
      tick      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], frame_clk};
      tick      <= sync_pipe[1] & ~sync_pipe[2];
    end
  end
endmodule

// File: rtl/trail_painter.sv
// Sole writer of the frame buffer: background sweep after reset/clear, then 4x4 trail blocks per frame tick.
module trail_painter
  import tron_pkg::*;
#(
  parameter int LINE_WORDS  = H_WORDS,
  parameter int FRAME_LINES = V_LINES
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           frame_clk,
  input  logic           clear_req,
  input  logic           paint_en,
  input  logic [9:0]     Blue_X_real,
  input  logic [9:0]     Blue_Y_real,
  input  logic [9:0]     Red_X_real,
  input  logic [9:0]     Red_Y_real,
  trail_painter_if.master fb,
  output logic           busy,
  output logic           clear_done
);
  localparam int          GW       = 2 * LINE_WORDS / CELL_PX;
  localparam int          GH       = FRAME_LINES / CELL_PX;
  localparam logic [17:0] CLR_LAST = 18'(LINE_WORDS * FRAME_LINES - 1);

  logic           tick, take, start;
  painter_state_t state, state_n;
  logic [17:0]    clr_cnt, clr_cnt_n;
  logic [2:0]     blk_cnt, blk_cnt_n;
  logic           pending, pending_n, clr_last, clr_last_n;
  cell_t          blue, blue_n, red, red_n, blue_in, red_in, sel;
  logic           we_q, we_n, busy_n;
  logic [18:0]    addr_q, addr_n, blk_addr;
  logic [15:0]    data_q, data_n;

  frame_tick_sync u_tick_sync (.Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .tick(tick));

  function automatic logic on_grid(cell_t p);
    return (p.x < 10'(GW)) && (p.y < 10'(GH));
  endfunction

  assign blue_in = {Blue_X_real, Blue_Y_real};
  assign red_in  = {Red_X_real, Red_Y_real};
  assign take    = tick & paint_en;
  assign sel     = (state == PAINT_R) ? red : blue;
  // blk_cnt walks rows in [2:1] and the two words of a row in [0]
  assign blk_addr = (19'(sel.y) * 19'(CELL_PX) + 19'(blk_cnt[2:1])) * 19'(LINE_WORDS)
                  + 19'(sel.x) * 19'(CELL_PX / 2) + 19'(blk_cnt[0]);

  always_comb begin
    state_n    = state;
    clr_cnt_n  = clr_cnt;
    blk_cnt_n  = blk_cnt;
    pending_n  = pending;
    clr_last_n = 1'b0;
    blue_n     = blue;
    red_n      = red;
    we_n       = 1'b0;
    addr_n     = addr_q;
    data_n     = data_q;
    start      = 1'b0;

    unique case (state)
      CLEAR: begin
        we_n   = 1'b1;
        addr_n = 19'(clr_cnt);
        data_n = pix_word(BG_COLOR);
        if (clr_cnt == CLR_LAST) begin
          state_n    = IDLE;
          clr_cnt_n  = '0;
          clr_last_n = 1'b1;
        end else begin
          clr_cnt_n = clr_cnt + 18'd1;
        end
      end
      IDLE: start = take;
      PAINT_B, PAINT_R: begin
        we_n      = 1'b1;
        addr_n    = blk_addr;
        data_n    = (state == PAINT_B) ? pix_word(BLUE_TRAIL) : pix_word(RED_TRAIL);
        blk_cnt_n = blk_cnt + 3'd1;
        if (take) pending_n = 1'b1;
        if (blk_cnt == 3'd7) begin
          if (state == PAINT_B && on_grid(red)) state_n = PAINT_R;
          else if (pending || take)             start   = 1'b1;
          else                                  state_n = IDLE;
        end
      end
      default: state_n = CLEAR;
    endcase

    // A new paint (fresh tick or pending repaint) re-latches both bikes
    if (start) begin
      blue_n    = blue_in;
      red_n     = red_in;
      blk_cnt_n = '0;
      pending_n = 1'b0;
      if (on_grid(blue_in))     state_n = PAINT_B;
      else if (on_grid(red_in)) state_n = PAINT_R;
      else                      state_n = IDLE;
    end

    // Clear issues address 0 immediately so the sweep starts the very next cycle
    if (clear_req) begin
      state_n    = CLEAR;
      we_n       = 1'b1;
      addr_n     = '0;
      data_n     = pix_word(BG_COLOR);
      clr_cnt_n  = 18'd1;
      blk_cnt_n  = '0;
      pending_n  = 1'b0;
      clr_last_n = 1'b0;
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      blk_cnt    <= '0;
      pending    <= 1'b0;
      clr_last   <= 1'b0;
      blue       <= '0;
      red        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_n;
      clr_cnt    <= clr_cnt_n;
      blk_cnt    <= blk_cnt_n;
      pending    <= pending_n;
      clr_last   <= clr_last_n;
      blue       <= blue_n;
      red        <= red_n;
      we_q       <= we_n;
      addr_q     <= addr_n;
      data_q     <= data_n;
      busy       <= busy_n;
      clear_done <= clr_last;
    end
  end

  assign fb.WE            = we_q;
  assign fb.write_address = addr_q;
  assign fb.Data_In       = data_q;
endmodule

// File: tb/tb_trail_painter.sv
// Bench for trail_painter on a reduced 320x24-word frame (grid 160x6) to keep sweeps short.
module tb_trail_painter;
  localparam int HW = 320, VL = 24, NW = HW * VL, GW = 160, GH = 6;

  logic       Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0, clear_req = 1'b0, paint_en = 1'b1;
  logic [9:0] bx_i = '0, by_i = '0, rx_i = '0, ry_i = '0;
  logic       busy, clear_done;

  trail_painter_if fb();

  trail_painter #(.LINE_WORDS(HW), .FRAME_LINES(VL)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .clear_req(clear_req),
    .paint_en(paint_en), .Blue_X_real(bx_i), .Blue_Y_real(by_i), .Red_X_real(rx_i),
    .Red_Y_real(ry_i), .fb(fb), .busy(busy), .clear_done(clear_done)
  );

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0, cyc = 0, cd_cnt = 0;
  logic [34:0] wq[$], exp_q[$];
  int wc[$];

  always @(negedge Clk) begin
    cyc++;
    if (fb.WE === 1'b1) begin
      wq.push_back({fb.write_address, fb.Data_In});
      wc.push_back(cyc);
    end
    if (clear_done === 1'b1) cd_cnt++;
  end

  task automatic step(int n = 1);
    repeat (n) begin @(negedge Clk); #1; end
  endtask

  // Expected writes of one paint: blue block then red block, each skipped when off-grid
  function automatic void model_paint(int bx, int by, int rx, int ry);
    int x, y;
    logic [15:0] w;
    for (int k = 0; k < 2; k++) begin
      x = (k == 0) ? bx : rx;
      y = (k == 0) ? by : ry;
      w = (k == 0) ? 16'h0606 : 16'h0404;
      if (x < GW && y < GH)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 2; c++)
            exp_q.push_back({19'((4 * y + r) * HW + 2 * x + c), w});
    end
  endfunction

  function automatic int first_diff();
    if (wq.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (wq[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic pulse(int hi, int lo);
    frame_clk = 1'b1; step(hi);
    frame_clk = 1'b0; step(lo);
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin step(); n++; end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle timeout busy=%b expected 0", name, busy);
    end
  endtask

  task automatic wait_busy(string name);
    int n = 0;
    while (busy !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy timeout busy=%b expected 1", name, busy);
    end
  endtask

  task automatic paint_once(int bx, int by, int rx, int ry);
    bx_i = 10'(bx); by_i = 10'(by); rx_i = 10'(rx); ry_i = 10'(ry);
    wq.delete(); wc.delete(); exp_q.delete();
    model_paint(bx, by, rx, ry);
    pulse(2, 2);
    step(4);
    wait_idle("paint");
    step(2);
  endtask

  task automatic test_sweep(string name, bit inject);
    int n = 0, bad = -1;
    while (cd_cnt == 0 && n < NW + 100) begin
      if (inject && n == 50) frame_clk = 1'b1;
      if (inject && n == 54) frame_clk = 1'b0;
      step(); n++;
    end
    frame_clk = 1'b0;
    step(3);
    foreach (wq[i]) if (bad < 0 && wq[i] !== {19'(i), 16'h0808}) bad = i;
    checks++;
    if (cd_cnt != 1) begin errors++; $display("FAIL %s clear_done pulses=%0d expected 1", name, cd_cnt); end
    checks++;
    if (wq.size() != NW) begin errors++; $display("FAIL %s sweep writes=%0d expected %0d", name, wq.size(), NW); end
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL %s sweep entry %0d got %h expected %h", name, bad, wq[bad], {19'(bad), 16'h0808});
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy after sweep=%b expected 0", name, busy); end
    wq.delete(); wc.delete(); cd_cnt = 0;
  endtask

  task automatic test_reset();
    step(3);
    checks++; if (fb.WE !== 1'b0) begin errors++; $display("FAIL reset_we got %b expected 0", fb.WE); end
    checks++; if (fb.write_address !== 19'd0) begin errors++; $display("FAIL reset_addr got %0d expected 0", fb.write_address); end
    checks++; if (fb.Data_In !== 16'h0) begin errors++; $display("FAIL reset_data got %h expected 0000", fb.Data_In); end
    checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_clear_done got %b expected 0", clear_done); end
    wq.delete(); cd_cnt = 0;
    Reset_n = 1'b1;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b expected 1", busy); end
    checks++;
    if (fb.WE !== 1'b1 || fb.write_address !== 19'd0) begin
      errors++; $display("FAIL reset_first_write we=%b addr=%0d expected we=1 addr=0", fb.WE, fb.write_address);
    end
    test_sweep("reset_sweep", 1'b1);
  endtask

  task automatic test_corners();
    int d, span;
    paint_once(0, 0, GW - 1, GH - 1);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL corners writes=%0d expected %0d diff_at=%0d got %h expected %h", wq.size(), exp_q.size(),
               d, (d >= 0) ? wq[d] : 35'h0, (d >= 0) ? exp_q[d] : 35'h0);
    end
    span = (wc.size() > 0) ? wc[wc.size() - 1] - wc[0] + 1 : 0;
    checks++;
    if (wc.size() != 16 || span != 16) begin
      errors++; $display("FAIL corners_cycles writes=%0d span=%0d expected 16/16", wc.size(), span);
    end
  endtask

  task automatic test_range();
    int d;
    int cases[3][4] = '{'{GW, 0, 10, 5}, '{3, 2, 10, GH}, '{1023, 1023, GW, 0}};
    for (int t = 0; t < 3; t++) begin
      paint_once(cases[t][0], cases[t][1], cases[t][2], cases[t][3]);
      d = first_diff();
      checks++;
      if (d != -1) begin
        errors++;
        $display("FAIL range_%0d writes=%0d expected %0d diff_at=%0d", t, wq.size(), exp_q.size(), d);
      end
    end
  endtask

  task automatic test_random();
    int d, bx, by, rx, ry;
    for (int t = 0; t < 10; t++) begin
      bx = $urandom_range(0, GW + 5); by = $urandom_range(0, GH + 1);
      rx = $urandom_range(0, GW + 5); ry = $urandom_range(0, GH + 1);
      paint_once(bx, by, rx, ry);
      d = first_diff();
      checks++;
      if (d != -1) begin
        errors++;
        $display("FAIL random_%0d b=(%0d,%0d) r=(%0d,%0d) writes=%0d expected %0d diff_at=%0d",
                 t, bx, by, rx, ry, wq.size(), exp_q.size(), d);
      end
    end
  endtask

  task automatic test_pending();
    int d, bx, by, rx, ry;
    bx = $urandom_range(0, GW - 1); by = $urandom_range(0, GH - 1);
    rx = $urandom_range(0, GW - 1); ry = $urandom_range(0, GH - 1);
    bx_i = 10'(bx); by_i = 10'(by); rx_i = 10'(rx); ry_i = 10'(ry);
    wq.delete(); wc.delete(); exp_q.delete();
    model_paint(bx, by, rx, ry);
    frame_clk = 1'b1; step(2); frame_clk = 0;
    wait_busy("pending_start");
    // moving bikes mid-paint must only affect the repaint
    bx = $urandom_range(0, GW - 1); by = $urandom_range(0, GH - 1);
    rx = $urandom_range(0, GW - 1); ry = $urandom_range(0, GH - 1);
    bx_i = 10'(bx); by_i = 10'(by); rx_i = 10'(rx); ry_i = 10'(ry);
    model_paint(bx, by, rx, ry);
    repeat (3) pulse(1, 2);
    wait_idle("pending");
    step(2);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++; $display("FAIL pending writes=%0d expected %0d diff_at=%0d", wq.size(), exp_q.size(), d);
    end
    paint_en = 1'b0;
    wq.delete();
    pulse(2, 2);
    step(20);
    checks++;
    if (wq.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL paint_disabled writes=%0d busy=%b expected 0/0", wq.size(), busy);
    end
    paint_en = 1'b1;
  endtask

  task automatic test_clear_abort();
    int n = 0, bad = 0;
    bx_i = 10'd7; by_i = 10'd3; rx_i = 10'd20; ry_i = 10'd4;
    wq.delete(); wc.delete(); exp_q.delete();
    model_paint(7, 3, 20, 4);
    pulse(2, 2);
    wait_busy("abort_start");
    frame_clk = 1'b1;
    while (wq.size() < 5 && n < 30) begin step(); n++; end
    frame_clk = 1'b0;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    checks++;
    if (fb.WE !== 1'b1 || fb.write_address !== 19'd0 || fb.Data_In !== 16'h0808) begin
      errors++;
      $display("FAIL abort_first_clear we=%b addr=%0d data=%h expected 1/0/0808", fb.WE, fb.write_address, fb.Data_In);
    end
    for (int i = 0; i < 5; i++) if (wq.size() <= i || wq[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || wq.size() < 5) begin
      errors++; $display("FAIL abort_prefix bad=%0d writes=%0d expected 0 bad", bad, wq.size());
    end
    repeat (5) if (wq.size() > 0) void'(wq.pop_front());
    test_sweep("abort_sweep", 1'b0);
    step(40);
    checks++;
    if (wq.size() != 0) begin errors++; $display("FAIL abort_pending writes=%0d expected 0", wq.size()); end
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    wq.delete(); cd_cnt = 0;
    clear_req = 1'b1; step(); clear_req = 1'b0;
    while (wq.size() < 5001 && n < 6000) begin step(); n++; end
    checks++;
    if (wq.size() < 5001 || wq[5000] !== {19'd5000, 16'h0808}) begin
      errors++; $display("FAIL midclear_reach writes=%0d expected >=5001", wq.size());
    end
    Reset_n = 1'b0;
    #1;
    checks++;
    if (fb.WE !== 1'b0) begin errors++; $display("FAIL async_reset_we got %b expected 0", fb.WE); end
    step(2);
    wq.delete(); cd_cnt = 0;
    Reset_n = 1'b1;
    step();
    checks++;
    if (fb.WE !== 1'b1 || fb.write_address !== 19'd0) begin
      errors++; $display("FAIL restart_first we=%b addr=%0d expected 1/0", fb.WE, fb.write_address);
    end
    test_sweep("restart_sweep", 1'b0);
  endtask

  initial begin
    test_reset();
    test_corners();
    test_range();
    test_random();
    test_pending();
    test_clear_abort();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
